carryadder_seq: RTL and testbench
=================================

Name: carryadder_seq

Overview:
- Multi-byte sequencer directly upstream of carryadder8. Drives it and collects what it produces.
- Accepts NBYTES-wide operands through a valid/ready slave port.
- Issues one carryadder8 transaction per byte, LSB first, chaining the carry between bytes.
- Returns the assembled sum, final carry and whole-word zero flag through a valid/ready master port.

Parameters:
- NBYTES, 4, operand width in bytes (legal range 1..16).
- TIMEOUT, 64, maximum cycles to wait for add_ready per byte (used only when CARRYSEQ_TIMEOUT_EN is defined).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_valid  in  1  operand request valid.
- s_ready  out  1  sequencer can accept a request.
- s_a  in  8*NBYTES  addend 0.
- s_b  in  8*NBYTES  addend 1.
- s_carry  in  1  carry-in to byte 0.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_sum  out  8*NBYTES  sum.
- m_carry  out  1  carry out of the top byte.
- m_zero  out  1  m_sum == 0; carry excluded.
- m_error  out  1  timeout abort; tied 0 when the feature is compiled out.
- add_enable  out  1  to carryadder8 rx_enable.
- add_write  out  1  to carryadder8 rx_write.
- add_strobe  out  1  to carryadder8 rx_strobe.
- add_carryflag  out  1  to carryadder8 rx_carryflag.
- add_addend0  out  8  to carryadder8 rx_addend0.
- add_addend1  out  8  to carryadder8 rx_addend1.
- add_sum  in  8  from carryadder8 tx_sum.
- add_carry  in  1  from carryadder8 tx_carryflag.
- add_zero  in  1  from carryadder8 tx_zeroflag.
- add_ready  in  1  from carryadder8 tx_ready.

Behaviour:
- Reset values: s_ready=1, m_valid=0, m_sum=0, m_carry=0, m_zero=0, m_error=0. All add_* outputs are 0.
- Reset is effective immediately, including mid-operation. In-flight carryadder8 results are discarded.
- FSM states are IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - s_ready=1.
  - On s_valid: latch s_a, s_b and s_carry into shift registers, clear the byte index, go to ISSUE.
- ISSUE (exactly one cycle):
  - add_enable=1, add_write=1, add_strobe=1.
  - add_addend0/1 = current low byte; add_carryflag = running carry.
  - Go to WAIT.
- WAIT:
  - add_enable=1; add_write and add_strobe are 0. Operands stay stable.
  - add_ready sampled high: shift add_sum into the top of the result register, update the running carry from add_carry, AND add_zero into the zero accumulator.
  - If index == NBYTES-1, go to DONE; otherwise increment the index, shift the operands and go to ISSUE.
- add_ready high during the ISSUE cycle is stale and is ignored.
- DONE:
  - m_valid=1. m_sum, m_carry and m_zero stay stable until m_ready is sampled high, then go to IDLE.
  - s_ready=0 in DONE, so there is no same-cycle re-accept. Throughput is one request per at least 2*NBYTES+2 cycles.
- Arithmetic: m_sum = (s_a + s_b + s_carry) mod 2^(8*NBYTES); m_carry = bit 8*NBYTES of the same sum.
- Boundary cases:
  - Wrap-around: all-ones + 1 gives m_sum=0, m_carry=1, m_zero=1.
  - s_valid arriving in a non-IDLE state is not acknowledged. The requester holds it.
- Minimum latency, s_valid accept to m_valid: 2*NBYTES+1 cycles, with add_ready arriving the cycle after the strobe.

Optional Feature:
- Macro: CARRYSEQ_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles. If the count reaches TIMEOUT without add_ready, go to DONE with m_error=1, m_sum=0, m_carry=0, m_zero=0.
  - m_error clears on the m_valid/m_ready handshake.
- Undefined: there is no counter, WAIT blocks indefinitely, and m_error is constant 0.

Decomposition:
- Package carryadder_pkg holds:
  - the FSM state enum (IDLE/ISSUE/WAIT/DONE);
  - the byte-width constant BYTE_W=8;
  - the default NBYTES and TIMEOUT values.
- No sub-module is needed; the sequencer is a single module.
- The bench instantiates carryadder_seq and carryadder8 back to back.

Test Plan:
- NBYTES=4: s_a=0x000000FF, s_b=0x00000001, s_carry=0 -> m_sum=0x00000100, m_carry=0, m_zero=0. Carry ripples from byte 0 into byte 1.
- s_a=0xFFFFFFFF, s_b=0x00000000, s_carry=1 -> m_sum=0, m_carry=1, m_zero=1. Exactly 4 add_strobe pulses.
- s_a=0x12345678, s_b=0x11111111 with m_ready held low 10 cycles -> m_valid held, m_sum=0x23456789 stable, s_ready=0 throughout.
- aresetn asserted during the third WAIT -> all outputs at reset values the same cycle. The next request 0x1+0x1 returns 0x00000002.
- Stale case: add_ready forced high during ISSUE -> ignored. The byte is captured only from add_ready in WAIT, and the sum is still correct.
- CARRYSEQ_TIMEOUT_EN, TIMEOUT=64, add_ready stuck 0 -> m_valid with m_error=1 after 64 WAIT cycles. m_error clears after the handshake.

Source files
------------

// File: rtl/carryadder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : carryadder_pkg
// Purpose  : Shared state encoding and sizing constants for carryadder_seq.
// Revision : 1.0
// ============================================================================
package carryadder_pkg;

   localparam int BYTE_W       = 8;
   localparam int NBYTES_DFLT  = 4;
   localparam int TIMEOUT_DFLT = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/carryadder_seq.sv
`default_nettype none
// ============================================================================
// Module   : carryadder_seq
// Purpose  : Splits a multi-byte add into LSB-first carryadder8 transactions.
//            Define CARRYSEQ_TIMEOUT_EN for a per-byte add_ready timeout.
// Revision : 1.0
// ============================================================================
module carryadder_seq
   import carryadder_pkg::*;
#(
   parameter int NBYTES  = NBYTES_DFLT,
   parameter int TIMEOUT = TIMEOUT_DFLT
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [BYTE_W*NBYTES-1:0] s_a,
   input  logic [BYTE_W*NBYTES-1:0] s_b,
   input  logic                     s_carry,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [BYTE_W*NBYTES-1:0] m_sum,
   output logic                     m_carry,
   output logic                     m_zero,
   output logic                     m_error,
   output logic                     add_enable,
   output logic                     add_write,
   output logic                     add_strobe,
   output logic                     add_carryflag,
   output logic [BYTE_W-1:0]        add_addend0,
   output logic [BYTE_W-1:0]        add_addend1,
   input  logic [BYTE_W-1:0]        add_sum,
   input  logic                     add_carry,
   input  logic                     add_zero,
   input  logic                     add_ready
);

   localparam int               W        = BYTE_W * NBYTES;
   localparam int               IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   if (NBYTES < 1 || NBYTES > 16 || TIMEOUT < 1) begin : g_bad_cfg
      $error("carryadder_seq: NBYTES must be 1..16 and TIMEOUT at least 1");
   end

   seq_state_e        state_q;
   logic [W-1:0]      a_q, b_q;       // operand bytes not yet issued
   logic [W-1:0]      acc_q;
   logic [IDX_W-1:0]  idx_q;
   logic              zacc_q;
   logic              s_ready_q, m_valid_q, m_carry_q, m_zero_q;
   logic [W-1:0]      m_sum_q;
   logic              add_enable_q, add_write_q, add_strobe_q, add_carryflag_q;
   logic [BYTE_W-1:0] add_addend0_q, add_addend1_q;

   logic [W-1:0]      acc_d;
   logic              zacc_d;

`ifdef CARRYSEQ_TIMEOUT_EN
   localparam int              TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   logic [TMO_W-1:0] tmo_q;
   logic             m_error_q;
`endif

   // Each returned byte enters at the top, so after NBYTES shifts byte 0 sits at the bottom.
   assign acc_d  = (acc_q >> BYTE_W) | (W'(add_sum) << (W - BYTE_W));
   assign zacc_d = zacc_q & add_zero;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q         <= IDLE;
         a_q             <= '0;
         b_q             <= '0;
         acc_q           <= '0;
         idx_q           <= '0;
         zacc_q          <= 1'b0;
         s_ready_q       <= 1'b1;
         m_valid_q       <= 1'b0;
         m_sum_q         <= '0;
         m_carry_q       <= 1'b0;
         m_zero_q        <= 1'b0;
         add_enable_q    <= 1'b0;
         add_write_q     <= 1'b0;
         add_strobe_q    <= 1'b0;
         add_carryflag_q <= 1'b0;
         add_addend0_q   <= '0;
         add_addend1_q   <= '0;
`ifdef CARRYSEQ_TIMEOUT_EN
         tmo_q           <= '0;
         m_error_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (s_valid) begin
                  a_q             <= s_a >> BYTE_W;
                  b_q             <= s_b >> BYTE_W;
                  idx_q           <= '0;
                  zacc_q          <= 1'b1;
                  s_ready_q       <= 1'b0;
                  add_enable_q    <= 1'b1;
                  add_write_q     <= 1'b1;
                  add_strobe_q    <= 1'b1;
                  add_addend0_q   <= s_a[BYTE_W-1:0];
                  add_addend1_q   <= s_b[BYTE_W-1:0];
                  add_carryflag_q <= s_carry;
                  state_q         <= ISSUE;
               end
            end

            ISSUE: begin
               add_write_q  <= 1'b0;
               add_strobe_q <= 1'b0;
`ifdef CARRYSEQ_TIMEOUT_EN
               tmo_q        <= '0;
`endif
               state_q      <= WAIT;
            end

            WAIT: begin
               if (add_ready) begin
                  acc_q  <= acc_d;
                  zacc_q <= zacc_d;
                  if (idx_q == LAST_IDX) begin
                     m_valid_q       <= 1'b1;
                     m_sum_q         <= acc_d;
                     m_carry_q       <= add_carry;
                     m_zero_q        <= zacc_d;
                     add_enable_q    <= 1'b0;
                     add_carryflag_q <= 1'b0;
                     add_addend0_q   <= '0;
                     add_addend1_q   <= '0;
                     state_q         <= DONE;
                  end else begin
                     idx_q           <= idx_q + IDX_W'(1);
                     a_q             <= a_q >> BYTE_W;
                     b_q             <= b_q >> BYTE_W;
                     add_addend0_q   <= a_q[BYTE_W-1:0];
                     add_addend1_q   <= b_q[BYTE_W-1:0];
                     add_carryflag_q <= add_carry;
                     add_write_q     <= 1'b1;
                     add_strobe_q    <= 1'b1;
                     state_q         <= ISSUE;
                  end
               end
`ifdef CARRYSEQ_TIMEOUT_EN
               else if (tmo_q == TMO_LAST) begin
                  m_valid_q       <= 1'b1;
                  m_error_q       <= 1'b1;
                  m_sum_q         <= '0;
                  m_carry_q       <= 1'b0;
                  m_zero_q        <= 1'b0;
                  add_enable_q    <= 1'b0;
                  add_carryflag_q <= 1'b0;
                  add_addend0_q   <= '0;
                  add_addend1_q   <= '0;
                  state_q         <= DONE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
`endif
            end

            DONE: begin
               if (m_ready) begin
                  m_valid_q <= 1'b0;
                  s_ready_q <= 1'b1;
`ifdef CARRYSEQ_TIMEOUT_EN
                  m_error_q <= 1'b0;
`endif
                  state_q   <= IDLE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_ready       = s_ready_q;
   assign m_valid       = m_valid_q;
   assign m_sum         = m_sum_q;
   assign m_carry       = m_carry_q;
   assign m_zero        = m_zero_q;
   assign add_enable    = add_enable_q;
   assign add_write     = add_write_q;
   assign add_strobe    = add_strobe_q;
   assign add_carryflag = add_carryflag_q;
   assign add_addend0   = add_addend0_q;
   assign add_addend1   = add_addend1_q;

`ifdef CARRYSEQ_TIMEOUT_EN
   assign m_error = m_error_q;
`else
   assign m_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_carryadder_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_carryadder_seq
// Purpose  : Directed bench for carryadder_seq against a behavioural carryadder8.
// Revision : 1.0
// ============================================================================
module tb_carryadder_seq;
   import carryadder_pkg::*;

   localparam int NB  = 4;
   localparam int TMO = 64;
   localparam int W   = BYTE_W * NB;

   logic             aclk = 1'b0;
   logic             aresetn = 1'b0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [W-1:0]     s_a = '0;
   logic [W-1:0]     s_b = '0;
   logic             s_carry = 1'b0;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [W-1:0]     m_sum;
   logic             m_carry, m_zero, m_error;
   logic             add_enable, add_write, add_strobe, add_carryflag;
   logic [7:0]       add_addend0, add_addend1, add_sum;
   logic             add_carry, add_zero, add_ready;

   int n_vec = 0;
   int n_err = 0;
   int strobe_cnt = 0;

   logic stale_mode = 1'b0;
   logic stuck_mode = 1'b0;

   always #5 aclk = ~aclk;

   carryadder_seq #(.NBYTES(NB), .TIMEOUT(TMO)) u_dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_carry(s_carry),
      .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_carry(m_carry),
      .m_zero(m_zero), .m_error(m_error),
      .add_enable(add_enable), .add_write(add_write), .add_strobe(add_strobe),
      .add_carryflag(add_carryflag), .add_addend0(add_addend0), .add_addend1(add_addend1),
      .add_sum(add_sum), .add_carry(add_carry), .add_zero(add_zero), .add_ready(add_ready)
   );

   // Behavioural carryadder8: answers the cycle after a strobe.
   logic       mdl_rdy_q = 1'b0;
   logic [7:0] mdl_sum_q = '0;
   logic       mdl_cy_q = 1'b0;
   always @(posedge aclk) begin
      {mdl_cy_q, mdl_sum_q} <= 9'(add_addend0) + 9'(add_addend1) + 9'(add_carryflag);
      mdl_rdy_q <= add_enable & add_write & add_strobe & ~stuck_mode;
      if (add_strobe) strobe_cnt <= strobe_cnt + 1;
   end
   // Stale mode raises add_ready with a poisoned result while the strobe is still up.
   assign add_ready = (mdl_rdy_q | (stale_mode & add_strobe)) & ~stuck_mode;
   assign add_sum   = (stale_mode & add_strobe) ? 8'hA5 : mdl_sum_q;
   assign add_carry = (stale_mode & add_strobe) ? 1'b1  : mdl_cy_q;
   assign add_zero  = (stale_mode & add_strobe) ? 1'b0  : (mdl_sum_q == 8'h00);

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_s_ready"},  W'(s_ready), W'(1));
      chk({tag, "_m_valid"},  W'(m_valid), W'(0));
      chk({tag, "_m_sum"},    m_sum, W'(0));
      chk({tag, "_m_carry"},  W'(m_carry), W'(0));
      chk({tag, "_m_zero"},   W'(m_zero), W'(0));
      chk({tag, "_m_error"},  W'(m_error), W'(0));
      chk({tag, "_enable"},   W'(add_enable), W'(0));
      chk({tag, "_write"},    W'(add_write), W'(0));
      chk({tag, "_strobe"},   W'(add_strobe), W'(0));
      chk({tag, "_cflag"},    W'(add_carryflag), W'(0));
      chk({tag, "_addend0"},  W'(add_addend0), W'(0));
      chk({tag, "_addend1"},  W'(add_addend1), W'(0));
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int k = 0;
      @(negedge aclk);
      while (s_ready !== 1'b1 && k < 100) begin
         @(negedge aclk);
         k++;
      end
      s_a = a; s_b = b; s_carry = c; s_valid = 1'b1;
      @(negedge aclk);
      s_valid = 1'b0;
   endtask

   task automatic wait_mvalid(input string tag, input int budget);
      int k = 0;
      while (m_valid !== 1'b1 && k < budget) begin
         @(negedge aclk);
         k++;
      end
      chk({tag, "_m_valid"}, W'(m_valid), W'(1));
   endtask

   task automatic ack();
      m_ready = 1'b1;
      @(negedge aclk);
      m_ready = 1'b0;
   endtask

   task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic [W-1:0] esum, input logic ec, input logic ez);
      send(a, b, c);
      wait_mvalid(tag, 40);
      chk({tag, "_sum"},   m_sum, esum);
      chk({tag, "_carry"}, W'(m_carry), W'(ec));
      chk({tag, "_zero"},  W'(m_zero), W'(ez));
      chk({tag, "_error"}, W'(m_error), W'(0));
      ack();
      chk({tag, "_idle_s_ready"}, W'(s_ready), W'(1));
      chk({tag, "_idle_m_valid"}, W'(m_valid), W'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap;
      int n;
      int k;

      repeat (3) @(negedge aclk);
      chk_reset("por");
      aresetn = 1'b1;

      run("ripple", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

      snap = strobe_cnt;
      run("wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
      chk("wrap_strobes", W'(strobe_cnt - snap), W'(4));

      // Hold the result for 10 cycles while a second request waits unacknowledged.
      send(32'h1234_5678, 32'h1111_1111, 1'b0);
      wait_mvalid("hold", 40);
      s_a = 32'h0000_0001; s_b = 32'h0000_0002; s_carry = 1'b0; s_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("hold_m_valid", W'(m_valid), W'(1));
         chk("hold_m_sum",   m_sum, 32'h2345_6789);
         chk("hold_s_ready", W'(s_ready), W'(0));
         @(negedge aclk);
      end
      m_ready = 1'b1;
      @(negedge aclk);
      m_ready = 1'b0;
      chk("hold_reaccept_s_ready", W'(s_ready), W'(1));
      @(negedge aclk);
      s_valid = 1'b0;
      wait_mvalid("queued", 40);
      chk("queued_sum", m_sum, 32'h0000_0003);
      ack();

      // Asynchronous reset during the WAIT of byte 2.
      send(32'hAABB_CCDD, 32'h1122_3344, 1'b0);
      n = 0;
      k = 0;
      while (k < 40) begin
         if (add_strobe === 1'b1) n++;
         if (n == 3) break;
         @(negedge aclk);
         k++;
      end
      chk("rst_third_strobe", W'(n), W'(3));
      @(negedge aclk);
      chk("rst_in_wait_enable", W'(add_enable), W'(1));
      #2 aresetn = 1'b0;
      #1 chk_reset("midrst");
      @(negedge aclk);
      aresetn = 1'b1;
      run("after_rst", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

      stale_mode = 1'b1;
      run("stale", 32'h89AB_CDEF, 32'h7654_3210, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      stale_mode = 1'b0;

      run("topcarry", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      run("cin_ripple", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
      run("allzero", 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1);

`ifdef CARRYSEQ_TIMEOUT_EN
      stuck_mode = 1'b1;
      send(32'h0102_0304, 32'h0506_0708, 1'b0);
      k = 0;
      while (m_valid !== 1'b1 && k < 200) begin
         @(negedge aclk);
         k++;
      end
      chk("tmo_cycles", W'(k), W'(TMO + 1));
      chk("tmo_error", W'(m_error), W'(1));
      chk("tmo_sum",   m_sum, W'(0));
      chk("tmo_carry", W'(m_carry), W'(0));
      chk("tmo_zero",  W'(m_zero), W'(0));
      ack();
      chk("tmo_error_clr", W'(m_error), W'(0));
      stuck_mode = 1'b0;
      run("tmo_recover", 32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
